// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, constants and address decode for the APB wait completer
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_cmp_state_e;

    localparam int CFG_WAIT_BITS = 4;
    localparam int APB_MAX_AW    = 64;

    // Word index of a byte address: drop the byte-lane bits, keep idx_w bits.
    function automatic logic [APB_MAX_AW-1:0] word_index(input logic [APB_MAX_AW-1:0] addr,
                                                          input int unsigned         idx_w);
        return (addr >> 2) & ~({APB_MAX_AW{1'b1}} << idx_w);
    endfunction

endpackage

// File: rtl/apb_wait_completer_if.sv
// rtl/apb_wait_completer_if.sv - APB bus bundle with requester and completer views
interface apb_wait_completer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_cmp_regbank.sv
// rtl/apb_cmp_regbank.sv - word storage plus CFG wait register, one write and one read port
module apb_cmp_regbank
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int WAIT_DEFAULT = 2,
    localparam int IDX_W       = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [CFG_WAIT_BITS-1:0] waits
);
    localparam logic [IDX_W-1:0] CFG_IDX = IDX_W'(DEPTH - 1);

    // The top entry shadows CFG and is never written, so it stays at zero.
    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]    mem_d [DEPTH];
    logic [CFG_WAIT_BITS-1:0] waits_q, waits_d;

    always_comb begin
        mem_d   = mem_q;
        waits_d = waits_q;
        if (we) begin
            if (wr_idx == CFG_IDX) begin
                waits_d = wr_data[CFG_WAIT_BITS-1:0];
            end else begin
                mem_d[wr_idx] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            waits_q <= CFG_WAIT_BITS'(WAIT_DEFAULT);
        end else begin
            mem_q   <= mem_d;
            waits_q <= waits_d;
        end
    end

    always_comb begin
        rd_data = mem_q[rd_idx];
        if (rd_idx == CFG_IDX) begin
            rd_data = DATA_WIDTH'(waits_q);
        end
    end

    assign waits = waits_q;

endmodule

// File: rtl/apb_wait_completer.sv
// rtl/apb_wait_completer.sv - APB completer with programmable wait states and error decode
module apb_wait_completer
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int WAIT_DEFAULT = 2
) (
    input  logic               PCLK,
    input  logic               PRESET,
    apb_wait_completer_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    apb_cmp_state_e           state_q, state_d;
    logic [CFG_WAIT_BITS-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     write_q, write_d;
    logic                     err_q, err_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0]    paddr;
    logic [IDX_W-1:0]         idx_in;
    logic                     err_in;
    logic                     setup;
    logic                     we;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic [CFG_WAIT_BITS-1:0] waits;
    logic                     ready;

    assign paddr  = bus.PADDR;
    assign idx_in = IDX_W'(word_index(APB_MAX_AW'(paddr), IDX_W));
    assign err_in = (paddr[1:0] != 2'b00) || ((paddr >> (IDX_W + 2)) != '0);
    assign setup  = bus.PSEL && !bus.PENABLE;

    apb_cmp_regbank #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (DEPTH),
        .WAIT_DEFAULT(WAIT_DEFAULT)
    ) u_regbank (
        .clk    (PCLK),
        .rst    (PRESET),
        .we     (we),
        .wr_idx (idx_q),
        .wr_data(wdata_q),
        .rd_idx (idx_in),
        .rd_data(rd_data),
        .waits  (waits)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // A dropped PSEL in ACCESS aborts the transfer without completing it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (setup) state_d = ACCESS;
            ACCESS:  if (!bus.PSEL || cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we      = 1'b0;
        if (state_q == IDLE) begin
            if (setup) begin
                cnt_d   = waits;
                idx_d   = idx_in;
                write_d = bus.PWRITE;
                err_d   = err_in;
                wdata_d = bus.PWDATA;
                rdata_d = err_in ? '0 : rd_data;
            end
        end else if (bus.PSEL) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                we = write_q && !err_q;
            end
        end
    end

    always_comb begin
        ready = (state_q == ACCESS) && (cnt_q == '0);
    end

    assign bus.PREADY  = ready;
    assign bus.PRDATA  = ready ? rdata_q : '0;
    assign bus.PSLVERR = ready && err_q;

endmodule

// File: doc/apb_wait_completer.md
# apb_wait_completer

APB completer with a word-addressed register bank, a runtime-programmable wait-state count, and error responses on bad addresses. It attaches to the PADDR/PSEL/PENABLE/PWRITE/PWDATA bus driven by `apb_master`. It lets benches and SoC tops exercise PREADY stretching and PSLVERR handling on the master side.

## Interface
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width (≥ 8)
- DEPTH, 16, number of words in the bank; power of two, ≥ 2
- WAIT_DEFAULT, 2, reset value of the wait count, 0..15
- One clock; reset is synchronous and active-high.
- PCLK  in  1  clock; all logic on the rising edge
- PRESET  in  1  synchronous active-high reset
- PADDR  in  ADDR_WIDTH  byte address
- PSEL  in  1  completer select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write, 0 = read
- PWDATA  in  DATA_WIDTH  write data
- PREADY  out  1  transfer completes this cycle
- PRDATA  out  DATA_WIDTH  read data, valid only when PREADY=1
- PSLVERR  out  1  error flag, valid only when PREADY=1

## Operation
- Address map:
  - Word index = PADDR[2 +: log2(DEPTH)].
  - Words 0..DEPTH-2 are read/write storage.
  - Word DEPTH-1 is CFG: bits [3:0] hold WAITS; upper bits read 0 and ignore writes.
- Error condition, decoded from the address captured at setup:
  - PADDR[1:0] ≠ 0, or
  - PADDR ≥ DEPTH*4.
- Error transfers:
  - A write does not modify any state.
  - A read returns PRDATA = 0.
  - Both complete with PSLVERR = 1.
- FSM states: IDLE, ACCESS.
  - IDLE: when PSEL=1 and PENABLE=0, capture addr, write and wdata; load the wait counter from WAITS; compute err; go to ACCESS. Any other input keeps IDLE.
  - ACCESS, with cnt ≠ 0: cnt decrements by 1; PREADY = 0.
  - ACCESS, with cnt = 0: PREADY = 1. At the end of this cycle a non-error write commits, the transfer completes, and the FSM returns to IDLE.
  - ACCESS, with PSEL = 0 (protocol violation): abort to IDLE next cycle, no write, no PREADY.
- Read data is fetched from the captured index when ACCESS is entered.
  - PRDATA is held while in ACCESS and is forced to 0 whenever PREADY = 0.
- A write to CFG changes the wait count for subsequent transfers only. The transfer doing the write completes with the old count.
- PREADY, PRDATA and PSLVERR are decoded from registered state only. There is no combinational path from any input to any output.

## Timing
- Reset values: PREADY = 0, PRDATA = 0, PSLVERR = 0, state = IDLE, storage words = 0, WAITS = WAIT_DEFAULT.
- Reset applied mid-transfer takes effect at the next edge. Any pending write is lost.
- Transfer timeline, with setup at cycle T:
  - ACCESS begins at T+1.
  - PREADY is high at cycle T+1+WAITS.
  - The write is visible to a read whose setup is at T+2+WAITS or later.
- WAITS = 0 gives the minimum two-cycle APB transfer.
- Back-to-back transfers: the completion cycle is followed by IDLE. A setup presented in that cycle is accepted, so there is no dead cycle beyond the APB setup phase.
- The counter is 4 bits wide and never wraps; it saturates at 0.

## Structure
- Shared package `apb_pkg` holds:
  - the state enum `apb_cmp_state_e` (IDLE, ACCESS),
  - the constant CFG_WAIT_BITS = 4,
  - the function `word_index` used for address decode.
- Sub-module `apb_cmp_regbank` holds storage plus CFG:
  - one synchronous write port (index, data, we),
  - one combinational read port,
  - WAITS exported as an output.
- The FSM, wait counter and error decode live in the top of `apb_wait_completer`.

## Test plan
- Reset with WAIT_DEFAULT = 2, then write 0xDEADBEEF to 0x04 and read it back:
  - PREADY rises 3 cycles after each setup.
  - The read returns 0xDEADBEEF with PSLVERR = 0.
- Write 0x0 to CFG (0x3C with DEPTH = 16), then read 0x04:
  - The CFG write itself completes after 2 waits.
  - The read completes in 2 cycles total.
  - CFG reads back as 0x0.
- Write 0x12345678 to 0x06 (unaligned) and to 0x40 (out of range):
  - Both complete with PSLVERR = 1.
  - Reading 0x00..0x38 shows no change.
- Read 0x41:
  - PRDATA = 0 and PSLVERR = 1 at PREADY.
  - PRDATA = 0 in every non-PREADY cycle.
- With WAITS = 5, drop PSEL in the 2nd ACCESS cycle of a write of 0xA5A5A5A5 to 0x08:
  - No PREADY is seen.
  - The FSM is back in IDLE next cycle.
  - A later read of 0x08 returns the old value.
- With WAITS = 4, assert PRESET during ACCESS of a write to 0x0C:
  - All outputs are 0 the next cycle.
  - Word 0x0C reads 0.
  - CFG reads back 2.
